// File: rtl/mfe_param.sv
// mfe_param: parametrised 3x3 rank filter over a raster image with zero padding.
// Reads pixels through a one-cycle-latency ROM port and writes one result
// per pixel, in raster order, to a result RAM port. The output is the median.
// Optional feature macro MFE_RANK_SEL_EN adds a `mode` input that selects
// median / minimum / maximum for the whole frame.
module mfe_param #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int DW    = 8,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  output logic [AW-1:0] iaddr,
  input  logic [DW-1:0] idata,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_wr,
  output logic          wen
`ifdef MFE_RANK_SEL_EN
  ,
  input  logic [1:0]    mode
`endif
);

  localparam logic [AW-1:0] W_A = AW'(IMG_W);
  localparam logic [AW-1:0] H_A = AW'(IMG_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD0,
    S_LOAD,
    S_SORT,
    S_WRITE,
    S_DONE
  } state_t;

  // Window columns: index 0 = L, 1 = C, 2 = R; rows 0..2 = y-1, y, y+1.
  localparam logic [1:0] COL_C = 2'd1;
  localparam logic [1:0] COL_R = 2'd2;

  state_t                    state_q, state_d;
  logic [1:0]                ph_q, ph_d;
  logic [AW-1:0]             x_q, x_d;
  logic [AW-1:0]             y_q, y_d;
  logic                      busy_q;
  logic [AW-1:0]             iaddr_q;
  logic [AW-1:0]             addr_q;
  logic [DW-1:0]             data_q;
  logic                      wen_q;
  logic [2:0][2:0][DW-1:0]   win_q;
  logic                      cap_v_q;
  logic                      cap_zero_q;
  logic [1:0]                cap_row_q;
  logic [1:0]                cap_col_q;
  logic                      shift_win;
  logic                      clr_win;
  logic                      start;
  logic                      cur_iss, cur_oob;
  logic                      nxt_iss, nxt_oob;
  logic [AW-1:0]             nxt_addr;
  logic [DW-1:0]             med_val;
  logic [DW-1:0]             rank_val;
`ifdef MFE_RANK_SEL_EN
  logic [1:0]                mode_q;
  logic [DW-1:0]             min_val;
  logic [DW-1:0]             max_val;
`endif

  // A read slot is issued in every LOAD0 phase and in LOAD phases 0..2;
  // LOAD phase 3 only captures the last returned pixel.
  function automatic logic slot_iss(input state_t st, input logic [1:0] ph);
    return (st == S_LOAD0) || ((st == S_LOAD) && (ph != 2'd3));
  endfunction

  function automatic logic [AW-1:0] slot_col(input state_t st, input logic [AW-1:0] x);
    return (st == S_LOAD0) ? '0 : (x + AW'(1));
  endfunction

  // Row index is carried as (row + 1) so y-1 never goes negative.
  function automatic logic slot_oob(input state_t st, input logic [1:0] ph,
                                    input logic [AW-1:0] x, input logic [AW-1:0] y);
    logic [AW-1:0] rowp1;
    rowp1 = y + AW'(ph);
    return (rowp1 == '0) || (rowp1 > H_A) || (slot_col(st, x) >= W_A);
  endfunction

  function automatic logic [AW-1:0] slot_addr(input state_t st, input logic [1:0] ph,
                                              input logic [AW-1:0] x, input logic [AW-1:0] y);
    logic [AW-1:0] row;
    row = y + AW'(ph) - AW'(1);
    return (row * W_A) + slot_col(st, x);
  endfunction

  function automatic logic [2*DW-1:0] cx(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? {a, b} : {b, a};
  endfunction

  function automatic logic [DW-1:0] mn(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DW-1:0] mx(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Next-state logic: frame sequencing, pixel counters and window control.
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    x_d       = x_q;
    y_d       = y_q;
    shift_win = 1'b0;
    clr_win   = 1'b0;
    start     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ready) begin
          state_d = S_LOAD0;
          ph_d    = '0;
          x_d     = '0;
          y_d     = '0;
          clr_win = 1'b1;
          start   = 1'b1;
        end
      end
      S_LOAD0: begin
        if (ph_q == 2'd2) begin
          state_d = S_LOAD;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 2'd1;
        end
      end
      S_LOAD: begin
        if (ph_q == 2'd3) begin
          state_d = S_SORT;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 2'd1;
        end
      end
      S_SORT: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        ph_d = '0;
        if (x_q == (W_A - AW'(1))) begin
          x_d = '0;
          y_d = y_q + AW'(1);
          if (y_q == (H_A - AW'(1))) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD0;
            clr_win = 1'b1;
          end
        end else begin
          x_d       = x_q + AW'(1);
          state_d   = S_LOAD;
          shift_win = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        y_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read-slot decode for the current cycle (capture tag) and the next
  // cycle (iaddr is registered, so it is computed one cycle ahead).
  always_comb begin
    cur_iss  = slot_iss(state_q, ph_q);
    cur_oob  = slot_oob(state_q, ph_q, x_q, y_q);
    nxt_iss  = slot_iss(state_d, ph_d);
    nxt_oob  = slot_oob(state_d, ph_d, x_d, y_d);
    nxt_addr = slot_addr(state_d, ph_d, x_d, y_d);
  end

  // 19 compare-exchange median-of-9 network.
  always_comb begin
    logic [8:0][DW-1:0] s;
    s = win_q;
    {s[2], s[1]} = cx(s[1], s[2]);
    {s[5], s[4]} = cx(s[4], s[5]);
    {s[8], s[7]} = cx(s[7], s[8]);
    {s[1], s[0]} = cx(s[0], s[1]);
    {s[4], s[3]} = cx(s[3], s[4]);
    {s[7], s[6]} = cx(s[6], s[7]);
    {s[2], s[1]} = cx(s[1], s[2]);
    {s[5], s[4]} = cx(s[4], s[5]);
    {s[8], s[7]} = cx(s[7], s[8]);
    {s[3], s[0]} = cx(s[0], s[3]);
    {s[8], s[5]} = cx(s[5], s[8]);
    {s[7], s[4]} = cx(s[4], s[7]);
    {s[6], s[3]} = cx(s[3], s[6]);
    {s[4], s[1]} = cx(s[1], s[4]);
    {s[5], s[2]} = cx(s[2], s[5]);
    {s[7], s[4]} = cx(s[4], s[7]);
    {s[2], s[4]} = cx(s[4], s[2]);
    {s[4], s[6]} = cx(s[6], s[4]);
    {s[2], s[4]} = cx(s[4], s[2]);
    med_val = s[4];
  end

`ifdef MFE_RANK_SEL_EN
  // Separate 8-compare min and max trees over the nine taps.
  always_comb begin
    logic [8:0][DW-1:0] t;
    t = win_q;
    min_val = mn(mn(mn(mn(t[0], t[1]), mn(t[2], t[3])),
                    mn(mn(t[4], t[5]), mn(t[6], t[7]))), t[8]);
    max_val = mx(mx(mx(mx(t[0], t[1]), mx(t[2], t[3])),
                    mx(mx(t[4], t[5]), mx(t[6], t[7]))), t[8]);
  end

  // Rank select for the frame; codes 00 and 11 both give the median.
  always_comb begin
    unique case (mode_q)
      2'b01:   rank_val = min_val;
      2'b10:   rank_val = max_val;
      default: rank_val = med_val;
    endcase
  end

  // Mode is sampled once, when the start request is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= '0;
    end else if (start) begin
      mode_q <= mode;
    end
  end
`else
  // Without rank selection the result is always the median.
  always_comb begin
    rank_val = med_val;
  end
`endif

  // Control, address and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      busy_q     <= 1'b0;
      iaddr_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wen_q      <= 1'b0;
      cap_v_q    <= 1'b0;
      cap_zero_q <= 1'b0;
      cap_row_q  <= '0;
      cap_col_q  <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      x_q        <= x_d;
      y_q        <= y_d;
      busy_q     <= (state_d != S_IDLE);
      wen_q      <= (state_d == S_WRITE);
      // Out-of-image slots keep the previous address on the bus.
      if (nxt_iss && !nxt_oob) begin
        iaddr_q <= nxt_addr;
      end
      cap_v_q    <= cur_iss;
      cap_zero_q <= cur_oob;
      cap_row_q  <= ph_q;
      cap_col_q  <= (state_q == S_LOAD0) ? COL_C : COL_R;
      if (state_q == S_SORT) begin
        data_q <= rank_val;
        addr_q <= (y_q * W_A) + x_q;
      end
    end
  end

  // Window: cleared at row start, shifted left per pixel, filled by captures.
  // The x=0 pixel fills C (LOAD0) then R (LOAD) without shifting in between.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q <= '0;
    end else if (clr_win) begin
      win_q <= '0;
    end else if (shift_win) begin
      win_q[0] <= win_q[1];
      win_q[1] <= win_q[2];
      win_q[2] <= '0;
    end else if (cap_v_q) begin
      win_q[cap_col_q][cap_row_q] <= cap_zero_q ? '0 : idata;
    end
  end

  assign busy    = busy_q;
  assign iaddr   = iaddr_q;
  assign addr    = addr_q;
  assign data_wr = data_q;
  assign wen     = wen_q;

endmodule
